// File: rtl/value_display.sv
// rtl/value_display.sv - 4-deep distinct-value history shown on a multiplexed 4-digit seven-segment display
module value_display #(
   parameter int REFRESH_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] value,
   output logic [3:0] sseg_an,
   output logic [6:0] sseg_ca,
   output logic       update
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [3:0]    value_q;
   logic          primed;
   logic [3:0]    hist [4];
   logic [2:0]    fill;
   logic [PW-1:0] presc;
   logic [1:0]    digit;
   logic          push;
   logic [6:0]    ca_next;

   // active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   always_comb begin
      push = !primed || (value != value_q);
   end

   // digits beyond the filled history stay blank
   always_comb begin
      ca_next = 7'h7F;
      if ({1'b0, digit} < fill) begin
         ca_next = glyph(hist[digit]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
         primed  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            hist[i] <= '0;
         end
         fill    <= '0;
         presc   <= '0;
         digit   <= '0;
         sseg_an <= 4'b1111;
         sseg_ca <= 7'h7F;
         update  <= 1'b0;
      end else begin
         value_q <= value;
         primed  <= 1'b1;
         update  <= push;
         if (push) begin
            hist[3] <= hist[2];
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= value;
            if (fill != 3'd4) begin
               fill <= fill + 3'd1;
            end
         end

         if (presc == PRESC_MAX) begin
            presc <= '0;
            digit <= digit + 2'd1;
         end else begin
            presc <= presc + 1'b1;
         end

         sseg_an <= ~(4'b0001 << digit);
         sseg_ca <= ca_next;
      end
   end

endmodule

// File: doc/value_display.md
# value_display

Downstream display stage for the 4-bit counters (binary and ring). It samples the counter `value` every clock and keeps a 4-deep history of distinct values, newest first. The history is shown on a 4-digit, common-anode, time-multiplexed seven-segment display as hex glyphs. It is the board-level consumer of the counter output and drives the display pins directly.

## Interface

- `REFRESH_DIV`, default 4: clock cycles each digit stays selected. Legal range is 1 or more; use 4 in simulation and about 100000 on the board.
- `clk`, input, 1 bit: the only clock; all state changes on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `value`, input, 4 bits: counter output, sampled every `clk`.
- `sseg_an`, output, 4 bits: digit anodes, active-low, one-hot; bit i selects digit i.
- `sseg_ca`, output, 7 bits: segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- `update`, output, 1 bit: one-cycle strobe, high in the cycle after a history push.

## Operation

- **Reset state:**
  - `sseg_an` = 4'b1111 and `sseg_ca` = 7'h7F.
  - `update` = 0.
  - History empty: fill = 0, `hist[0..3]` = 0.
  - Prescaler = 0, digit index = 0, primed = 0.
- **Capture:**
  - On the first rising edge after reset release, `value` is pushed unconditionally and primed is set to 1.
  - After that, `value` is pushed only when it differs from `value_q`, the value registered on the previous edge.
  - `value_q` is loaded every edge.
- **Push:**
  - `hist[3]<=hist[2]`, `hist[2]<=hist[1]`, `hist[1]<=hist[0]`, `hist[0]<=value`.
  - fill increments and saturates at 4.
  - `update` <= 1 on a push edge, otherwise 0.
- **Scan:**
  - The prescaler counts 0 to `REFRESH_DIV`-1 and wraps.
  - On the wrap edge, the digit index advances 0→1→2→3→0 (2-bit, natural wrap).
  - The prescaler width is `$clog2(REFRESH_DIV)`, minimum 1 bit.
  - With `REFRESH_DIV`=1 the digit advances every edge.
- **Output registers:** every edge, the outputs are loaded as follows.
  - `sseg_an` <= ~(4'b0001 << digit).
  - `sseg_ca` <= glyph(`hist[digit]`) if digit < fill, else 7'h7F (blank).
  - Both are computed from the pre-edge register values.
- **Glyph table (active-low gfedcba):**
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Capture/push and scan are independent and may occur on the same edge; neither delays the other.

## Timing

- Edges are numbered from 1, the first rising edge after `rst` falls.
- **Edge 1:**
  - Push of `value`; `update` is high after this edge.
  - Outputs: `sseg_an`=1110, `sseg_ca`=7F (fill was 0 before the edge).
- **Edge 2:** `sseg_ca` = glyph of the edge-1 value.
- **Capture-to-display latency:** a value pushed on edge k is visible on `sseg_ca` after edge k+1, provided digit 0 is selected.
- **Digit change:** the digit index changes on edges `REFRESH_DIV`, 2·`REFRESH_DIV`, and so on. The matching `sseg_an` change follows one edge later.
- **Selection window:** each anode is low for exactly `REFRESH_DIV` consecutive cycles. Exactly one anode bit is low at any time after edge 1.
- **Changing input:** a `value` that changes every cycle is pushed every cycle, and `update` stays high continuously.
- **Reset mid-operation:**
  - Outputs go to their reset values immediately, without waiting for a clock.
  - History, fill and primed clear.
  - After release, the sequence restarts at edge 1.
- **No glitches:** there is no combinational path from `value` to any output.

## Test plan

All scenarios use `REFRESH_DIV`=4.

1. Pulse `rst` high mid-scan, between clock edges. Required: `sseg_an`=1111, `sseg_ca`=7F, `update`=0 before the next edge.
2. Release reset with `value`=0 held constant.
   - After edge 2: `sseg_an`=1110, `sseg_ca`=40.
   - `update` high for exactly one cycle.
   - Digits 1–3 show 7F while selected.
3. Binary counter enabled, `value` 0..9 one per cycle, then held at 9.
   - History = {9,8,7,6}.
   - Scan shows 10, 00, 78, 02 on digits 0–3.
   - `update` high for exactly 10 cycles.
4. Free-running scan check.
   - `sseg_an` follows 1110, 1101, 1011, 0111, 1110.
   - Each state is held for exactly 4 cycles; never zero or more than one bit low.
5. Ring counter sequence 1, 2, 4, 8, 1.
   - History = {1,8,4,2}.
   - Glyphs 79, 00, 19, 24.
   - A value of 5 held for 100 cycles produces no further `update` pulses.
6. Push A, b, C, d, E, F in sequence. Required: digits 0–3 show 0E, 06, 21, 46.
